imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares one single-port instruction memory between two requesters: the core fetch
//  unit (port F, read-only) and the program loader/debug port (port L, read/write).
//  Sits between the fetch stage / loader and the word-addressed instruction memory.
//  Converts byte addresses to word addresses, arbitrates per cycle with fetch priority
//  plus a starvation guard for L, and routes each 1-cycle-latency read to its owner.
// PARAMETERS
//  bus        32    data and byte-address width
//  aw         12    memory word-address width (4096 words)
//  starve_max 4     consecutive denied L cycles after which L wins the next slot (>=1)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  reset      in   1    asynchronous reset, active-low (0 = reset)
//  f_req      in   1    fetch read request
//  f_addr     in   bus  fetch byte address
//  f_gnt      out  1    fetch request accepted this cycle
//  f_rvalid   out  1    f_rdata valid (one cycle after f_gnt)
//  f_rdata    out  bus  fetch read data
//  f_misalign out  1    pulse: granted f_addr[1:0]!=0
//  l_req      in   1    loader request
//  l_we       in   1    loader write (1) / read (0)
//  l_addr     in   bus  loader byte address
//  l_wdata    in   bus  loader write data
//  l_gnt      out  1    loader request accepted this cycle
//  l_rvalid   out  1    l_rdata valid (one cycle after read l_gnt; never for writes)
//  l_rdata    out  bus  loader read data
//  mem_en     out  1    memory access this cycle
//  mem_we     out  1    memory write strobe
//  mem_addr   out  aw   memory word address
//  mem_wdata  out  bus  memory write data
//  mem_rdata  in   bus  memory read data, valid the cycle after mem_en&!mem_we
// BEHAVIOUR
//  - Grants combinational from req and state; at most one of f_gnt/l_gnt high; no request
//    is held internally: a requester keeps req/addr stable until it sees its gnt.
//  - Priority: F wins when both request, unless starve_cnt==starve_max, then L wins.
//  - starve_cnt: +1 (saturating at starve_max) each cycle l_req high and l_gnt low;
//    cleared on l_gnt or when l_req low.
//  - mem_en = f_gnt|l_gnt; mem_we = l_gnt&l_we; mem_addr = granted addr[aw+1:2];
//    mem_wdata = l_wdata (don't-care when !mem_we). Idle: mem_en=0, mem_we=0.
//  - Address bits above aw+1 ignored (wrap modulo 2^aw words); bits [1:0] ignored
//    for the access, f_misalign pulses with f_gnt if f_addr[1:0]!=0.
//  - Response tracking: registered owner (NONE/F/L) set on each read grant; next cycle
//    the owner's rvalid=1 and its rdata=mem_rdata; other rdata holds its last value.
//  - Back-to-back grants allowed every cycle, including alternating F/L; a write grant
//    sets owner NONE (no rvalid).
//  - Reset (async, reset=0): owner=NONE, starve_cnt=0, f_rvalid=l_rvalid=0,
//    f_rdata=l_rdata=0, f_misalign=0; grants and mem_en forced 0 while reset=0.
//    A read granted in the cycle reset asserts yields no rvalid.
//  - Latency: req to gnt 0 cycles (if won), gnt to rvalid 1 cycle.
// TESTING
//  1 Reset: reset=0 with f_req=l_req=1 -> all grants, mem_en, rvalids, rdata = 0.
//  2 F only: f_addr=0x0000_0010 -> f_gnt, mem_addr=4; next cycle f_rvalid=1, f_rdata=mem[4].
//  3 Contention, starve_max=4: f_req,l_req held high -> F granted 4 cycles, L on 5th,
//    then F again; L read returns l_rvalid exactly one cycle after l_gnt.
//  4 Loader write l_addr=0x40 wdata=0xE3A0_0001 -> mem_we=1, mem_addr=16, no l_rvalid;
//    following F read of 0x40 returns 0xE3A0_0001.
//  5 Misaligned/wrap: f_addr=0x0000_4006 -> mem_addr=1, f_misalign pulse with f_gnt.
//  6 Reset mid-read: reset=0 in cycle after F grant -> f_rvalid stays 0, starve_cnt=0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, the loader port and the instruction-memory port.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface imem_port_arbiter_if #(
  parameter int bus = 32,
  parameter int aw  = 12
);
  // Fetch port (read-only)
  logic           f_req;
  logic [bus-1:0] f_addr;
  logic           f_gnt;
  logic           f_rvalid;
  logic [bus-1:0] f_rdata;
  logic           f_misalign;

  // Loader / debug port (read/write)
  logic           l_req;
  logic           l_we;
  logic [bus-1:0] l_addr;
  logic [bus-1:0] l_wdata;
  logic           l_gnt;
  logic           l_rvalid;
  logic [bus-1:0] l_rdata;

  // Word-addressed single-port memory
  logic           mem_en;
  logic           mem_we;
  logic [aw-1:0]  mem_addr;
  logic [bus-1:0] mem_wdata;
  logic [bus-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_misalign,
           l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_misalign,
           l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction memory between the fetch unit (F) and the
// loader/debug port (L). Fetch has priority; a starvation counter lets L win
// after starve_max consecutive denied cycles. Reads have one cycle of latency
// and are routed back to whichever port owned the grant.
module imem_port_arbiter #(
  parameter int bus        = 32,
  parameter int aw         = 12,
  parameter int starve_max = 4
) (
  input  logic               clk,
  input  logic               reset,   // asynchronous, active-low
  imem_port_arbiter_if.slave bus_if
);

  localparam int cw = $clog2(starve_max + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  owner_e          owner_q, owner_d;
  logic [cw-1:0]   starve_cnt_q, starve_cnt_d;
  logic [bus-1:0]  f_hold_q, l_hold_q;

  logic            l_prio;
  logic            f_gnt, l_gnt;

  // Address bits that never reach the memory: the word index wraps modulo 2^aw
  // and loader byte offsets are simply dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_if.f_addr[bus-1:aw+2],
                              bus_if.l_addr[bus-1:aw+2],
                              bus_if.l_addr[1:0]};

  // Grant decision: fetch first unless the loader has been starved long enough.
  // Both grants are held low while reset is asserted.
  assign l_prio = (starve_cnt_q == cw'(starve_max));
  assign f_gnt  = reset & bus_if.f_req & (~bus_if.l_req | ~l_prio);
  assign l_gnt  = reset & bus_if.l_req & (~bus_if.f_req |  l_prio);

  assign bus_if.f_gnt      = f_gnt;
  assign bus_if.l_gnt      = l_gnt;
  assign bus_if.f_misalign = f_gnt & (|bus_if.f_addr[1:0]);

  // Memory side: a single access per cycle from whichever port won.
  assign bus_if.mem_en    = f_gnt | l_gnt;
  assign bus_if.mem_we    = l_gnt & bus_if.l_we;
  assign bus_if.mem_addr  = f_gnt ? bus_if.f_addr[aw+1:2] : bus_if.l_addr[aw+1:2];
  assign bus_if.mem_wdata = bus_if.l_wdata;

  // Response routing: the owner sees live memory data, the other port keeps its last word.
  assign bus_if.f_rvalid = (owner_q == OWN_F);
  assign bus_if.l_rvalid = (owner_q == OWN_L);
  assign bus_if.f_rdata  = (owner_q == OWN_F) ? bus_if.mem_rdata : f_hold_q;
  assign bus_if.l_rdata  = (owner_q == OWN_L) ? bus_if.mem_rdata : l_hold_q;

  // Next owner and starvation count from this cycle's grants.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;

    if (f_gnt) begin
      owner_d = OWN_F;
    end else if (l_gnt && !bus_if.l_we) begin
      owner_d = OWN_L;
    end

    if (!bus_if.l_req || l_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < cw'(starve_max)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State registers: owner, starvation counter and per-port read-data holds.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the hold registers are reset so rdata reads as zero until the first response.
    if (!reset) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      f_hold_q     <= '0;
      l_hold_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      if (owner_q == OWN_F) f_hold_q <= bus_if.mem_rdata;
      if (owner_q == OWN_L) l_hold_q <= bus_if.mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: single-cycle vector table followed by
// hand-written contention and reset-during-read sequences.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  imem_port_arbiter_if #(.bus(32), .aw(12)) ifc ();

  imem_port_arbiter #(.bus(32), .aw(12), .starve_max(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (ifc)
  );

  always #5 clk = ~clk;

  // Memory model: 4096 words preloaded with 0xA500_0000 + index, one-cycle read latency.
  logic [31:0] mem [4096];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      ifc.mem_rdata <= 32'h0;
    end else if (ifc.mem_en) begin
      if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
      else            ifc.mem_rdata <= mem[ifc.mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld);
    ifc.f_req   = fr;
    ifc.f_addr  = fa;
    ifc.l_req   = lr;
    ifc.l_we    = lw;
    ifc.l_addr  = la;
    ifc.l_wdata = ld;
  endtask

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        e_f_gnt;
    logic        e_l_gnt;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [11:0] e_mem_addr;
    logic        e_misalign;
    logic        e_f_rvalid;
    logic        e_l_rvalid;
    logic [31:0] e_f_rdata;
    logic [31:0] e_l_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    //                f_req f_addr        l_req l_we l_addr        l_wdata        fg lg en we addr    mis frv lrv f_rdata        l_rdata
    vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,         0, 0, 0, 0, 12'h000, 0,  0,  0,  32'h0,         32'h0};
    vecs[1] = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        32'h0,         1, 0, 1, 0, 12'h004, 0,  0,  0,  32'h0,         32'h0};
    vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,         0, 0, 0, 0, 12'h000, 0,  1,  0,  32'hA500_0004, 32'h0};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h20,       32'h0,         0, 1, 1, 0, 12'h008, 0,  0,  0,  32'hA500_0004, 32'h0};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h40,       32'hE3A0_0001, 0, 1, 1, 1, 12'h010, 0,  0,  1,  32'hA500_0004, 32'hA500_0008};
    vecs[5] = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        32'h0,         1, 0, 1, 0, 12'h010, 0,  0,  0,  32'hA500_0004, 32'hA500_0008};
    vecs[6] = '{1'b1, 32'h4006,     1'b1, 1'b0, 32'h0C,       32'h0,         1, 0, 1, 0, 12'h001, 1,  1,  0,  32'hE3A0_0001, 32'hA500_0008};
    vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFC,32'h0,         0, 1, 1, 0, 12'hFFF, 0,  1,  0,  32'hA500_0001, 32'hA500_0008};
    vecs[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,         0, 0, 0, 0, 12'h000, 0,  0,  1,  32'hA500_0001, 32'hA500_0FFF};

    // Reset held with both ports requesting: nothing may be granted or returned.
    reset = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk); #1;
    check("rst_f_gnt",    32'(ifc.f_gnt),      32'h0);
    check("rst_l_gnt",    32'(ifc.l_gnt),      32'h0);
    check("rst_mem_en",   32'(ifc.mem_en),     32'h0);
    check("rst_mem_we",   32'(ifc.mem_we),     32'h0);
    check("rst_f_rvalid", 32'(ifc.f_rvalid),   32'h0);
    check("rst_l_rvalid", 32'(ifc.l_rvalid),   32'h0);
    check("rst_f_rdata",  ifc.f_rdata,         32'h0);
    check("rst_l_rdata",  ifc.l_rdata,         32'h0);
    check("rst_misalign", 32'(ifc.f_misalign), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle vector table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req, vecs[i].l_we,
            vecs[i].l_addr, vecs[i].l_wdata);
      #1;
      check($sformatf("v%0d_f_gnt", i),    32'(ifc.f_gnt),      32'(vecs[i].e_f_gnt));
      check($sformatf("v%0d_l_gnt", i),    32'(ifc.l_gnt),      32'(vecs[i].e_l_gnt));
      check($sformatf("v%0d_mem_en", i),   32'(ifc.mem_en),     32'(vecs[i].e_mem_en));
      check($sformatf("v%0d_mem_we", i),   32'(ifc.mem_we),     32'(vecs[i].e_mem_we));
      check($sformatf("v%0d_misalign", i), 32'(ifc.f_misalign), 32'(vecs[i].e_misalign));
      check($sformatf("v%0d_f_rvalid", i), 32'(ifc.f_rvalid),   32'(vecs[i].e_f_rvalid));
      check($sformatf("v%0d_l_rvalid", i), 32'(ifc.l_rvalid),   32'(vecs[i].e_l_rvalid));
      check($sformatf("v%0d_f_rdata", i),  ifc.f_rdata,         vecs[i].e_f_rdata);
      check($sformatf("v%0d_l_rdata", i),  ifc.l_rdata,         vecs[i].e_l_rdata);
      if (vecs[i].e_mem_en)
        check($sformatf("v%0d_mem_addr", i), 32'(ifc.mem_addr), 32'(vecs[i].e_mem_addr));
      if (vecs[i].e_mem_we)
        check($sformatf("v%0d_mem_wdata", i), ifc.mem_wdata, vecs[i].l_wdata);
    end

    // Contention: F wins four cycles, L the fifth, then F again; L read returns next cycle.
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h0);
      #1;
      check($sformatf("ct%0d_f_gnt", k),    32'(ifc.f_gnt),    32'(k != 5));
      check($sformatf("ct%0d_l_gnt", k),    32'(ifc.l_gnt),    32'(k == 5));
      check($sformatf("ct%0d_mem_addr", k), 32'(ifc.mem_addr), (k == 5) ? 32'd32 : 32'd64);
      check($sformatf("ct%0d_l_rvalid", k), 32'(ifc.l_rvalid), 32'(k == 6));
      check($sformatf("ct%0d_f_rvalid", k), 32'(ifc.f_rvalid), 32'(k > 1 && k != 6));
      if (k == 6) check("ct_l_rdata", ifc.l_rdata, 32'hA500_0020);
      if (k == 7) check("ct_f_rdata", ifc.f_rdata, 32'hA500_0040);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the cycle after an F grant, with the starvation counter built up to 4.
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
      #1;
      check($sformatf("pre%0d_f_gnt", k), 32'(ifc.f_gnt), 32'h1);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_f_rvalid", 32'(ifc.f_rvalid), 32'h0);
    check("mid_f_rdata",  ifc.f_rdata,       32'h0);
    check("mid_f_gnt",    32'(ifc.f_gnt),    32'h0);
    check("mid_mem_en",   32'(ifc.mem_en),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    // A surviving starvation count would hand this slot to L.
    check("post_f_gnt", 32'(ifc.f_gnt), 32'h1);
    check("post_l_gnt", 32'(ifc.l_gnt), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("post_f_rvalid", 32'(ifc.f_rvalid), 32'h1);
    check("post_f_rdata",  ifc.f_rdata,       32'hA500_0002);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
